// File: rtl/phy_regfile_pkg.sv
// phy_regfile_pkg: shared sizing for the physical register file
package phy_regfile_pkg;
  localparam int PHY_REG_NUM      = 64;
  localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);
  localparam int REG_DATA_WIDTH   = 32;
  localparam int READREG_WIDTH    = 2;
  localparam int RENAME_WIDTH     = 2;
  localparam int EXECUTE_UNIT_NUM = 4;
endpackage

// File: rtl/phy_regfile_ready_table.sv
// phy_regfile_ready_table: per-entry ready bits, flush > allocate > write
module phy_regfile_ready_table
  import phy_regfile_pkg::*;
#(
  parameter int N  = PHY_REG_NUM,
  parameter int IW = PHY_REG_ID_WIDTH,
  parameter int AP = RENAME_WIDTH,
  parameter int WP = EXECUTE_UNIT_NUM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] alloc_id [AP],
  input  logic          alloc_valid [AP],
  input  logic [IW-1:0] wb_id [WP],
  input  logic          wb_we [WP],
  input  logic          flush,
  output logic [N-1:0]  ready
);
  logic [N-1:0] nxt;
  // later loops override earlier ones, giving allocate precedence over write
  always_comb begin
    nxt = ready;
    for (int k = 0; k < WP; k++) if (wb_we[k]) nxt[wb_id[k]] = 1'b1;
    for (int a = 0; a < AP; a++) if (alloc_valid[a]) nxt[alloc_id[a]] = 1'b0;
    nxt = flush ? '1 : nxt;
    nxt[0] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ready <= '1;
    else ready <= nxt;
endmodule

// File: rtl/phy_regfile.sv
// phy_regfile: physical register file with combinational reads and ready tracking
module phy_regfile
  import phy_regfile_pkg::*;
#(
  parameter int PHY_REG_NUM_P = PHY_REG_NUM,
  parameter int READ_PORTS    = READREG_WIDTH,
  parameter int ALLOC_PORTS   = RENAME_WIDTH,
  parameter int WRITE_PORTS   = EXECUTE_UNIT_NUM,
  parameter int DATA_WIDTH    = REG_DATA_WIDTH,
  parameter int IW            = $clog2(PHY_REG_NUM_P)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IW-1:0]         readreg_phyf_id [READ_PORTS][2],
  output logic [DATA_WIDTH-1:0] phyf_readreg_data [READ_PORTS][2],
  output logic                  phyf_readreg_data_valid [READ_PORTS][2],
  input  logic [IW-1:0]         rename_phyf_alloc_id [ALLOC_PORTS],
  input  logic                  rename_phyf_alloc_valid [ALLOC_PORTS],
  input  logic [IW-1:0]         wb_phyf_id [WRITE_PORTS],
  input  logic [DATA_WIDTH-1:0] wb_phyf_data [WRITE_PORTS],
  input  logic                  wb_phyf_we [WRITE_PORTS],
  input  logic                  commit_phyf_flush
);
  logic [DATA_WIDTH-1:0] data [PHY_REG_NUM_P];
  logic [PHY_REG_NUM_P-1:0] ready;
  phy_regfile_ready_table #(
    .N(PHY_REG_NUM_P), .IW(IW), .AP(ALLOC_PORTS), .WP(WRITE_PORTS)
  ) u_ready (
    .clk(clk),
    .rst(rst),
    .alloc_id(rename_phyf_alloc_id),
    .alloc_valid(rename_phyf_alloc_valid),
    .wb_id(wb_phyf_id),
    .wb_we(wb_phyf_we),
    .flush(commit_phyf_flush),
    .ready(ready)
  );
  // entry 0 is never written, so it holds its reset value of zero forever
  always_ff @(posedge clk or negedge rst)
    if (!rst) data <= '{default: '0};
    else
      for (int k = 0; k < WRITE_PORTS; k++)
        if (wb_phyf_we[k] && wb_phyf_id[k] != '0) data[wb_phyf_id[k]] <= wb_phyf_data[k];
  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    for (genvar j = 0; j < 2; j++) begin : g_src
      assign phyf_readreg_data[i][j]       = data[readreg_phyf_id[i][j]];
      assign phyf_readreg_data_valid[i][j] = ready[readreg_phyf_id[i][j]];
    end
  end
endmodule

// File: tb/tb_phy_regfile.sv
// tb_phy_regfile: model-based and literal checks of phy_regfile
module tb_phy_regfile;
  logic clk = 0;
  logic rst = 0;
  logic [5:0]  rid [2][2];
  logic [31:0] rdata [2][2];
  logic        rvalid [2][2];
  logic [5:0]  aid [2];
  logic        aval [2];
  logic [5:0]  wid [4];
  logic [31:0] wd [4];
  logic        we [4];
  logic        flush;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_data [64];
  bit          m_rdy [64];

  phy_regfile dut (
    .clk(clk), .rst(rst),
    .readreg_phyf_id(rid), .phyf_readreg_data(rdata), .phyf_readreg_data_valid(rvalid),
    .rename_phyf_alloc_id(aid), .rename_phyf_alloc_valid(aval),
    .wb_phyf_id(wid), .wb_phyf_data(wd), .wb_phyf_we(we),
    .commit_phyf_flush(flush)
  );

  always #5 clk = ~clk;

  // reference model: what each entry must hold after every edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < 64; e++) begin
        m_data[e] = 0;
        m_rdy[e] = 1;
      end
    end else begin
      for (int e = 1; e < 64; e++) begin
        bit al, wr;
        al = 0;
        wr = 0;
        for (int a = 0; a < 2; a++) if (aval[a] && aid[a] == e) al = 1;
        for (int k = 0; k < 4; k++) if (we[k] && wid[k] == e) begin
          wr = 1;
          m_data[e] = wd[k];
        end
        if (flush) m_rdy[e] = 1;
        else if (al) m_rdy[e] = 0;
        else if (wr) m_rdy[e] = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("model_data[%0d][%0d] id %0d", i, j, rid[i][j]), rdata[i][j], m_data[rid[i][j]]);
        chk($sformatf("model_valid[%0d][%0d] id %0d", i, j, rid[i][j]), {31'b0, rvalid[i][j]}, {31'b0, m_rdy[rid[i][j]]});
      end

  task automatic clear();
    for (int a = 0; a < 2; a++) begin aid[a] = 0; aval[a] = 0; end
    for (int k = 0; k < 4; k++) begin wid[k] = 0; wd[k] = 0; we[k] = 0; end
    flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear();
  endtask

  task automatic rd(input int a, input int b, input int c, input int d);
    rid[0][0] = 6'(a); rid[0][1] = 6'(b); rid[1][0] = 6'(c); rid[1][1] = 6'(d);
    #1;
  endtask

  initial begin
    clear();
    rd(5, 63, 5, 63);
    @(posedge clk); #2;
    chk("reset_data5", rdata[0][0], 0);
    chk("reset_valid63", {31'b0, rvalid[0][1]}, 1);
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("post_reset_data63", rdata[0][1], 0);
    chk("post_reset_valid5", {31'b0, rvalid[0][0]}, 1);
    tick();
    // allocate 10, write it two edges later
    aid[0] = 10; aval[0] = 1; rd(10, 10, 10, 10);
    tick(); rd(10, 10, 10, 10);
    chk("alloc10_valid_c2", {31'b0, rvalid[0][0]}, 0);
    tick(); rd(10, 10, 10, 10);
    chk("alloc10_valid_c3", {31'b0, rvalid[1][1]}, 0);
    wid[0] = 10; wd[0] = 32'hDEADBEEF; we[0] = 1;
    tick(); rd(10, 10, 10, 10);
    chk("wb10_data", rdata[1][0], 32'hDEADBEEF);
    chk("wb10_valid", {31'b0, rvalid[1][0]}, 1);
    aid[1] = 12; aval[1] = 1; wid[2] = 12; wd[2] = 32'h5555AAAA; we[2] = 1;
    tick(); rd(12, 12, 12, 12);
    chk("allocwb12_valid", {31'b0, rvalid[0][1]}, 0);
    chk("allocwb12_data", rdata[0][1], 32'h5555AAAA);
    aid[0] = 20; aval[0] = 1; aid[1] = 21; aval[1] = 1;
    tick(); rd(20, 21, 22, 12);
    chk("alloc20_valid", {31'b0, rvalid[0][0]}, 0);
    flush = 1; aid[0] = 22; aval[0] = 1;
    tick(); rd(20, 21, 22, 12);
    chk("flush_valid20", {31'b0, rvalid[0][0]}, 1);
    chk("flush_valid21", {31'b0, rvalid[0][1]}, 1);
    chk("flush_valid22", {31'b0, rvalid[1][0]}, 1);
    chk("flush_valid12", {31'b0, rvalid[1][1]}, 1);
    wid[1] = 0; wd[1] = 32'h1234; we[1] = 1; aid[0] = 0; aval[0] = 1;
    tick(); rd(0, 0, 0, 0);
    chk("id0_data", rdata[0][0], 0);
    chk("id0_valid", {31'b0, rvalid[0][0]}, 1);
    for (int k = 0; k < 4; k++) begin wid[k] = 6'(7 + k); wd[k] = 32'(7 + k); we[k] = 1; end
    tick(); rd(7, 8, 9, 10);
    chk("all_p00", rdata[0][0], 32'h7);
    chk("all_p01", rdata[0][1], 32'h8);
    chk("all_p10", rdata[1][0], 32'h9);
    chk("all_p11", rdata[1][1], 32'hA);
    chk("all_valid", {28'b0, rvalid[0][0], rvalid[0][1], rvalid[1][0], rvalid[1][1]}, 32'hF);
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 4; k++) begin
        wid[k] = 6'(16 * k + $urandom_range(0, 15)); wd[k] = $urandom; we[k] = 1'($urandom);
      end
      for (int a = 0; a < 2; a++) begin aid[a] = 6'($urandom); aval[a] = 1'($urandom); end
      flush = ($urandom_range(0, 7) == 0);
      rid[0][0] = 6'($urandom); rid[0][1] = wid[0]; rid[1][0] = wid[3]; rid[1][1] = aid[0];
      @(posedge clk); #1;
    end
    clear();
    // reset mid-cycle must discard the pending alloc and write
    wid[0] = 31; wd[0] = 32'hCAFE0001; we[0] = 1; aid[0] = 30; aval[0] = 1;
    rd(30, 31, 10, 7);
    #1 rst = 0;
    #1;
    chk("midrst_data10", rdata[1][0], 0);
    chk("midrst_valid30", {31'b0, rvalid[0][0]}, 1);
    tick(); tick();
    rst = 1;
    #1;
    chk("after_rst_data31", rdata[0][1], 0);
    chk("after_rst_valid31", {31'b0, rvalid[0][1]}, 1);
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
